// File: rtl/parity_frame_accum.sv
// Frame parity accumulator: XOR-reduces WIDTH-bit words across a frame and
// presents parity, optional mismatch flag and word count once per frame.
module parity_frame_accum #(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 16,
  parameter int CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             odd_mode,
  input  logic             check_en,
  input  logic             exp_parity,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic             out_err,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WORDS);

  state_t           state, state_n;
  logic             acc, acc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             valid_n, par_n, err_n;
  logic [CNT_W-1:0] count_n;
  logic             acc_beat;
  logic [CNT_W-1:0] cnt_inc;

  // in_ready depends on state only, never on in_valid
  assign in_ready = (state == ACCUM);
  assign acc_beat = acc ^ (^in_data);
  assign cnt_inc  = cnt + 1'b1;

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    valid_n = out_valid;
    par_n   = out_parity;
    err_n   = out_err;
    count_n = out_count;
    case (state)
      ACCUM: begin
        // acc_beat is only consumed on a beat, so X data while idle stays out
        if (in_valid) begin
          if (in_last || (cnt_inc == LAST_CNT)) begin
            par_n   = acc_beat ^ odd_mode;
            err_n   = check_en & (acc_beat ^ odd_mode ^ exp_parity);
            count_n = cnt_inc;
            valid_n = 1'b1;
            acc_n   = 1'b0;
            cnt_n   = '0;
            state_n = HOLD;
          end else begin
            acc_n = acc_beat;
            cnt_n = cnt_inc;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_n = 1'b0;
          state_n = ACCUM;
        end
      end
      default: state_n = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      acc        <= 1'b0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_parity <= 1'b0;
      out_err    <= 1'b0;
      out_count  <= '0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      cnt        <= cnt_n;
      out_valid  <= valid_n;
      out_parity <= par_n;
      out_err    <= err_n;
      out_count  <= count_n;
    end
  end

endmodule

// File: tb/tb_parity_frame_accum.sv
// Directed bench for parity_frame_accum (WIDTH=8, MAX_WORDS=4).
module tb_parity_frame_accum;

  localparam int WIDTH     = 8;
  localparam int MAX_WORDS = 4;
  localparam int CNT_W     = $clog2(MAX_WORDS + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             odd_mode;
  logic             check_en;
  logic             exp_parity;
  logic             out_valid;
  logic             out_ready;
  logic             out_parity;
  logic             out_err;
  logic [CNT_W-1:0] out_count;

  int vectors = 0;
  int miscompares = 0;

  parity_frame_accum #(.WIDTH(WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .odd_mode(odd_mode), .check_en(check_en), .exp_parity(exp_parity),
    .out_valid(out_valid), .out_ready(out_ready), .out_parity(out_parity),
    .out_err(out_err), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One beat: drive just after a rising edge, hold across the next edge.
  task automatic send(input logic [WIDTH-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 'x;
    in_last  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_result(input string tag, input logic par, input logic err,
                            input logic [CNT_W-1:0] cnt);
    @(negedge clk);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".parity"}, 32'(out_parity), 32'(par));
    chk({tag, ".err"}, 32'(out_err), 32'(err));
    chk({tag, ".count"}, 32'(out_count), 32'(cnt));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 'x; in_last = 1'b0;
    odd_mode = 1'b0; check_en = 1'b0; exp_parity = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.parity", 32'(out_parity), 32'd0);
    chk("rst.err", 32'(out_err), 32'd0);
    chk("rst.count", 32'(out_count), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    // single word, even then odd: 0x07 has three ones
    send(8'h07, 1'b1);
    chk_result("even1", 1'b1, 1'b0, 3'd1);
    step();
    @(negedge clk);
    chk("even1.valid_fall", 32'(out_valid), 32'd0);
    chk("even1.in_ready_back", 32'(in_ready), 32'd1);
    chk("even1.parity_held", 32'(out_parity), 32'd1);
    odd_mode = 1'b1;
    send(8'h07, 1'b1);
    chk_result("odd1", 1'b0, 1'b0, 3'd1);
    step();

    // three-word frame: 1 ^ 0 ^ 1 = 0
    odd_mode = 1'b0;
    send(8'h01, 1'b0);
    send(8'h03, 1'b0);
    send(8'h07, 1'b1);
    chk_result("three", 1'b0, 1'b0, 3'd3);
    step();

    // truncation at 4 words, then a 2-word frame
    repeat (4) send(8'h01, 1'b0);
    chk_result("trunc1", 1'b0, 1'b0, 3'd4);
    step();
    send(8'h01, 1'b0);
    send(8'h01, 1'b1);
    chk_result("trunc2", 1'b0, 1'b0, 3'd2);
    step();

    // backpressure: result held while next word waits
    out_ready = 1'b0;
    send(8'h01, 1'b1);
    in_valid = 1'b1; in_data = 8'h81; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk_result("bp_hold", 1'b1, 1'b0, 3'd1);
    end
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp.valid_fall", 32'(out_valid), 32'd0);
    chk("bp.in_ready_back", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0; in_data = 'x; in_last = 1'b0;
    chk_result("bp_next", 1'b0, 1'b0, 3'd1);
    step();

    // check mode: 0xFF ^ 0x01 -> parity 1
    check_en = 1'b1; exp_parity = 1'b0;
    send(8'hFF, 1'b0);
    send(8'h01, 1'b1);
    chk_result("chk_mis", 1'b1, 1'b1, 3'd2);
    step();
    exp_parity = 1'b1;
    send(8'hFF, 1'b0);
    send(8'h01, 1'b1);
    chk_result("chk_ok", 1'b1, 1'b0, 3'd2);
    step();
    check_en = 1'b0; exp_parity = 1'b0;
    send(8'hFF, 1'b0);
    send(8'h01, 1'b1);
    chk_result("chk_off", 1'b1, 1'b0, 3'd2);
    step();

    // reset mid-frame: outputs clear immediately, no residue afterwards
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst.valid", 32'(out_valid), 32'd0);
    chk("mrst.parity", 32'(out_parity), 32'd0);
    chk("mrst.err", 32'(out_err), 32'd0);
    chk("mrst.count", 32'(out_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send(8'h03, 1'b1);
    chk_result("post_rst", 1'b0, 1'b0, 3'd1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parity_frame_accum.md
Name: parity_frame_accum

Overview:
- Parametrised successor to the fixed 3-input XOR gate: generalises to WIDTH-bit words and accumulates parity across a multi-word frame.
- Adds even/odd mode, an optional check against expected parity, and valid/ready handshakes on input and output.
- Sits between a word-stream source and a link/status consumer.
- Generates the frame parity bit, or flags a parity mismatch, once per frame.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- MAX_WORDS, 16, maximum words per frame; frame is force-closed at this count (>=1).
- CNT_W, $clog2(MAX_WORDS+1), width of the word counter and out_count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  WIDTH  data word.
- in_last  input  1  final word of frame.
- odd_mode  input  1  0 = even parity, 1 = odd parity; sampled on the closing beat.
- check_en  input  1  enable comparison against exp_parity; sampled on the closing beat.
- exp_parity  input  1  expected frame parity; sampled on the closing beat.
- out_valid  output  1  frame result available.
- out_ready  input  1  consumer accepts the result.
- out_parity  output  1  frame parity bit.
- out_err  output  1  mismatch flag: check_en && (out_parity != exp_parity).
- out_count  output  CNT_W  number of words in the reported frame (1..MAX_WORDS).

Behaviour:
- Clock and reset: one clock domain. rst_n is asynchronous active-low, asserted asynchronously and released synchronously by the system.
- Reset state: state=ACCUM, acc=0, cnt=0, out_valid=0, out_parity=0, out_err=0, out_count=0. in_ready=1 once rst_n is high.
- States:
  - ACCUM: collecting words. in_ready=1.
  - HOLD: result presented. in_ready=0.
- Beat: a word transfers when in_valid && in_ready. No transfer when in_valid=0, and in_data is ignored.
- Accumulation on each ACCUM beat:
  - acc_n = acc ^ (^in_data), i.e. the XOR reduction of all WIDTH bits.
  - cnt_n = cnt+1.
- Closing beat: a beat where in_last=1 OR cnt+1 == MAX_WORDS. Truncation at MAX_WORDS is silent; the next word starts a new frame. On the closing beat, at the next edge:
  - out_parity <= acc_n ^ odd_mode
  - out_err <= check_en & ((acc_n ^ odd_mode) ^ exp_parity)
  - out_count <= cnt+1
  - out_valid <= 1
  - acc <= 0, cnt <= 0
  - state <= HOLD
- Non-closing beat: acc <= acc_n, cnt <= cnt_n, and the block stays in ACCUM.
- Latency: the result is registered one cycle after the closing beat. A single-word frame uses a closing beat at cycle N and gives out_valid at N+1.
- HOLD:
  - out_parity, out_err and out_count stay stable while out_valid=1 && out_ready=0.
  - When out_ready=1: out_valid <= 0 and state <= ACCUM.
  - in_ready rises the cycle after the handshake, so there is one bubble cycle per frame. Throughput is 1 frame per (words+1) cycles minimum.
- out_err=0 whenever check_en=0 at the closing beat.
- Flags are held after the handshake: out_parity, out_err and out_count keep their last values after out_valid falls, until the next closing beat.
- in_valid during HOLD: no transfer. The source holds the word, as required by the valid/ready rules.
- Reset mid-frame: partial acc/cnt are discarded, any pending result is dropped, and outputs return to reset values immediately.
- MAX_WORDS=1: every beat is a closing beat and in_last is don't-care.
- Input rules: X on in_data with in_valid=0 must not propagate. No combinational path from in_valid to in_ready.

Test Plan:
- Even-mode single word: WIDTH=8, reset, then in_data=0x07 with in_last=1 and odd_mode=0. Required: out_valid next cycle, out_parity=1, out_count=1, out_err=0. Repeat with odd_mode=1: out_parity=0.
- Three-word frame: words 0x01, 0x03, 0x07 (last on third), even mode. Required: out_parity=0 (1^0^1), out_count=3, in_ready low during HOLD.
- Truncation: MAX_WORDS=4, 6 words of 0x01 with no in_last. Required: first result out_count=4, out_parity=0; second frame (2 words, last) out_count=2, out_parity=0.
- Backpressure: hold out_ready=0 for 5 cycles after a result. Required: out_valid=1 and outputs stable, in_ready=0, input words not consumed. Release out_ready: out_valid falls, in_ready=1 one cycle later.
- Check mode: frame 0xFF, 0x01 with check_en=1, exp_parity=0, even mode. Required: out_parity=1, out_err=1. Repeat with exp_parity=1: out_err=0. With check_en=0: out_err=0.
- Reset mid-frame: 2 beats of 0x01, then assert rst_n low. Required: all outputs 0 immediately. After release, frame 0x03 with in_last gives out_parity=0 and out_count=1, with no residue from the earlier beats.
